// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts apu_clk rising edges and emits
// quarter/half-frame strobes plus the 4-step frame IRQ.
module apu_frame_counter #(
  parameter int CNT_W = 15,
  parameter int STEP1 = 3728,
  parameter int STEP2 = 7456,
  parameter int STEP3 = 11185,
  parameter int STEP4 = 14914,
  parameter int STEP5 = 18640
) (
  input  logic clk,
  input  logic reset,
  input  logic apu_clk,
  input  logic wr_en,
  input  logic wr_mode,
  input  logic wr_irq_inhibit,
  input  logic irq_ack,
  output logic quarter_frame,
  output logic half_frame,
  output logic frame_irq
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             apu_clk_d_q, apu_clk_d_d;
  logic             quarter_q, quarter_d;
  logic             half_q, half_d;
  logic             irq_q, irq_d;
  logic             tick;
  logic             irq_set;
  logic             irq_clr;

  assign tick = apu_clk & ~apu_clk_d_q;

  always_comb begin
    count_d     = count_q;
    mode_d      = mode_q;
    inhibit_d   = inhibit_q;
    apu_clk_d_d = apu_clk;
    quarter_d   = 1'b0;
    half_d      = 1'b0;
    irq_set     = 1'b0;
    if (wr_en) begin
      mode_d    = wr_mode;
      inhibit_d = wr_irq_inhibit;
      count_d   = '0;
      quarter_d = wr_mode;
      half_d    = wr_mode;
    end else if (tick) begin
      unique case (1'b1)
        (count_q == S1),
        (count_q == S3): begin
          quarter_d = 1'b1;
          count_d   = count_q + 1'b1;
        end
        (count_q == S2): begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          count_d   = count_q + 1'b1;
        end
        (!mode_q && count_q == S4): begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          irq_set   = !inhibit_q;
          count_d   = '0;
        end
        (mode_q && count_q == S5): begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          count_d   = '0;
        end
        default: count_d = count_q + 1'b1;
      endcase
    end
  end

  // A set on the final 4-step tick beats a simultaneous clear.
  assign irq_clr = irq_ack | (wr_en & wr_irq_inhibit);

  always_comb begin
    irq_d = irq_q;
    if (irq_set)      irq_d = 1'b1;
    else if (irq_clr) irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      mode_q      <= 1'b0;
      inhibit_q   <= 1'b0;
      apu_clk_d_q <= 1'b1;
      quarter_q   <= 1'b0;
      half_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      mode_q      <= mode_d;
      inhibit_q   <= inhibit_d;
      apu_clk_d_q <= apu_clk_d_d;
      quarter_q   <= quarter_d;
      half_q      <= half_d;
      irq_q       <= irq_d;
    end
  end

  assign quarter_frame = quarter_q;
  assign half_frame    = half_q;
  assign frame_irq     = irq_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter with reduced step counts
// and a 3-high/3-low apu_clk.
module tb_apu_frame_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic apu_clk = 1'b1;
  logic wr_en = 1'b0;
  logic wr_mode = 1'b0;
  logic wr_irq_inhibit = 1'b0;
  logic irq_ack = 1'b0;
  logic quarter_frame;
  logic half_frame;
  logic frame_irq;

  int checks = 0;
  int errors = 0;

  logic q, h, irq;

  apu_frame_counter #(
    .CNT_W(15),
    .STEP1(3),
    .STEP2(7),
    .STEP3(11),
    .STEP4(14),
    .STEP5(18)
  ) dut (
    .clk(clk),
    .reset(reset),
    .apu_clk(apu_clk),
    .wr_en(wr_en),
    .wr_mode(wr_mode),
    .wr_irq_inhibit(wr_irq_inhibit),
    .irq_ack(irq_ack),
    .quarter_frame(quarter_frame),
    .half_frame(half_frame),
    .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Expected {quarter, half} after tick k of a frame starting at count 0.
  function automatic logic [1:0] exp_qh(input logic m, input int k);
    int p;
    int r;
    p = m ? 19 : 15;
    r = ((k - 1) % p) + 1;
    exp_qh[1] = (r == 4) || (r == 8) || (r == 12) || (r == p);
    exp_qh[0] = (r == 8) || (r == p);
  endfunction

  // One apu_clk period; optional ack/write driven on the tick clk.
  task automatic period(input logic ack, input logic wr,
                        input logic wm, input logic wi,
                        output logic oq, output logic oh,
                        output logic oirq);
    logic extra;
    extra = 1'b0;
    apu_clk = 1'b1;
    irq_ack = ack;
    wr_en = wr;
    wr_mode = wm;
    wr_irq_inhibit = wi;
    clk1();
    oq = quarter_frame;
    oh = half_frame;
    oirq = frame_irq;
    irq_ack = 1'b0;
    wr_en = 1'b0;
    wr_mode = 1'b0;
    wr_irq_inhibit = 1'b0;
    for (int i = 1; i < 6; i++) begin
      if (i == 3) apu_clk = 1'b0;
      clk1();
      extra = extra | quarter_frame | half_frame;
    end
    chk("pulse_width", extra, 1'b0);
  endtask

  task automatic run(input logic m, input int k0, input int n,
                     input int irq_at);
    logic [1:0] e;
    logic rq, rh, ri;
    for (int k = k0; k < k0 + n; k++) begin
      period(1'b0, 1'b0, 1'b0, 1'b0, rq, rh, ri);
      e = exp_qh(m, k);
      chk($sformatf("quarter_m%0d_t%0d", m, k), rq, e[1]);
      chk($sformatf("half_m%0d_t%0d", m, k), rh, e[0]);
      chk($sformatf("irq_m%0d_t%0d", m, k), ri,
          (irq_at > 0) && (k >= irq_at));
    end
  endtask

  initial begin
    // reset held with apu_clk high; release must not tick
    clk1();
    clk1();
    chk("rst_quarter", quarter_frame, 1'b0);
    chk("rst_half", half_frame, 1'b0);
    chk("rst_irq", frame_irq, 1'b0);
    reset = 1'b0;
    clk1();
    chk("rel_no_tick", quarter_frame | half_frame, 1'b0);
    apu_clk = 1'b0;
    repeat (3) clk1();

    // mode 0 from reset: two frames, IRQ from tick 15
    run(1'b0, 1, 30, 15);

    irq_ack = 1'b1;
    clk1();
    irq_ack = 1'b0;
    chk("ack_clears", frame_irq, 1'b0);

    // ack coincident with set tick: set wins
    run(1'b0, 31, 14, 0);
    period(1'b1, 1'b0, 1'b0, 1'b0, q, h, irq);
    chk("ack_set_q", q, 1'b1);
    chk("ack_set_h", h, 1'b1);
    chk("ack_set_irq", irq, 1'b1);

    // inhibit write clears and blocks IRQ
    wr_en = 1'b1;
    wr_irq_inhibit = 1'b1;
    clk1();
    wr_en = 1'b0;
    wr_irq_inhibit = 1'b0;
    chk("inh_clear_irq", frame_irq, 1'b0);
    chk("inh_no_q", quarter_frame, 1'b0);
    chk("inh_no_h", half_frame, 1'b0);
    run(1'b0, 1, 30, 0);

    // inhibit released: IRQ 15 ticks later
    wr_en = 1'b1;
    clk1();
    wr_en = 1'b0;
    chk("uninh_irq", frame_irq, 1'b0);
    run(1'b0, 1, 15, 15);

    irq_ack = 1'b1;
    clk1();
    irq_ack = 1'b0;
    chk("ack2_clears", frame_irq, 1'b0);

    // 5-step mode: immediate strobes, 19-tick period, no IRQ
    wr_en = 1'b1;
    wr_mode = 1'b1;
    clk1();
    wr_en = 1'b0;
    wr_mode = 1'b0;
    chk("m1_wr_q", quarter_frame, 1'b1);
    chk("m1_wr_h", half_frame, 1'b1);
    clk1();
    chk("m1_wr_q_end", quarter_frame, 1'b0);
    chk("m1_wr_h_end", half_frame, 1'b0);
    run(1'b1, 1, 38, 0);

    // write on the STEP2 tick wins; frame restarts
    run(1'b1, 1, 7, 0);
    period(1'b0, 1'b1, 1'b0, 1'b0, q, h, irq);
    chk("wr_tick_q", q, 1'b0);
    chk("wr_tick_h", h, 1'b0);
    run(1'b0, 1, 4, 0);

    // reset at count 9 with apu_clk rising
    run(1'b0, 5, 5, 0);
    apu_clk = 1'b1;
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("mid_rst_q", quarter_frame, 1'b0);
    chk("mid_rst_h", half_frame, 1'b0);
    chk("mid_rst_irq", frame_irq, 1'b0);
    clk1();
    clk1();
    chk("mid_rst_no_tick", quarter_frame | half_frame, 1'b0);
    apu_clk = 1'b0;
    repeat (3) clk1();
    run(1'b0, 1, 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
